// File: rtl/rcagb.sv
// Generate-based G-bit ripple-carry adder: one full-adder cell per bit.
module rcagb #(
    parameter int unsigned G = 8
) (
    input  logic [G-1:0] a,
    input  logic [G-1:0] b,
    input  logic         cin,
    output logic [G-1:0] s,
    output logic         cout
);

    logic [G:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < G; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[G];

endmodule

// File: rtl/rca_chunk_seq.sv
// Multi-precision add sequencer: reuses one G-bit ripple-carry adder over N chunks,
// LSB chunk first, with a registered inter-chunk carry.
module rca_chunk_seq #(
    parameter int unsigned G = 8,
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic           abort,
    input  logic [G*N-1:0] a,
    input  logic [G*N-1:0] b,
    input  logic           cin,
    output logic [G*N-1:0] sum,
    output logic           carry,
    output logic           done,
    output logic           busy
);

    localparam int unsigned W    = G * N;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    work_q, work_d;
    logic            carry_reg_q, carry_reg_d;
    logic [W-1:0]    sum_d;
    logic            carry_d;
    logic            done_d;

    logic [G-1:0]    chunk_a, chunk_b, chunk_s;
    logic            chunk_cout;
    logic [W-1:0]    work_next;

    always_comb begin
        chunk_a = a_q[int'(idx_q)*G +: G];
        chunk_b = b_q[int'(idx_q)*G +: G];
    end

    rcagb #(
        .G(G)
    ) u_rcagb (
        .a   (chunk_a),
        .b   (chunk_b),
        .cin (carry_reg_q),
        .s   (chunk_s),
        .cout(chunk_cout)
    );

    // Partial result with the current chunk merged in; becomes sum on the last chunk.
    always_comb begin
        work_next = work_q;
        work_next[int'(idx_q)*G +: G] = chunk_s;
    end

    assign start_ready = (state_q == StIdle) & rst_n;
    assign busy        = (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        work_d      = work_q;
        carry_reg_d = carry_reg_q;
        sum_d       = sum;
        carry_d     = carry;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    a_d         = a;
                    b_d         = b;
                    carry_reg_d = cin;
                    idx_d       = '0;
                    state_d     = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    work_d      = work_next;
                    carry_reg_d = chunk_cout;
                    if (idx_q == IdxLast) begin
                        sum_d   = work_next;
                        carry_d = chunk_cout;
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            work_q      <= '0;
            carry_reg_q <= 1'b0;
            sum         <= '0;
            carry       <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            work_q      <= work_d;
            carry_reg_q <= carry_reg_d;
            sum         <= sum_d;
            carry       <= carry_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_rca_chunk_seq.sv
// Randomized and directed bench for rca_chunk_seq against an arithmetic reference model.
module tb_rca_chunk_seq;

    localparam int unsigned G = 8;
    localparam int unsigned N = 4;
    localparam int unsigned W = G * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic         abort;
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] sum;
    logic         carry;
    logic         done;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Last completed result as the model sees it.
    logic [W-1:0] exp_sum;
    logic         exp_carry;

    always #5 clk = ~clk;

    rca_chunk_seq #(
        .G(G),
        .N(N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .abort      (abort),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .sum        (sum),
        .carry      (carry),
        .done       (done),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
    endtask

    // Run the N chunk edges after acceptance, then the done edge, checking timing and result.
    task automatic finish_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                             input bit keep_inputs);
        logic [W:0] r;
        r = {1'b0, oa} + {1'b0, ob} + {{W{1'b0}}, oc};
        for (int k = 1; k <= int'(N); k++) begin
            check("busy_run", 64'(busy), 64'(1));
            check("ready_run", 64'(start_ready), 64'(0));
            check("done_early", 64'(done), 64'(0));
            check("sum_hold_run", 64'(sum), 64'(exp_sum));
            if (!keep_inputs) scramble();
            step();
        end
        check("done_pulse", 64'(done), 64'(1));
        check("sum", 64'(sum), 64'(r[W-1:0]));
        check("carry", 64'(carry), 64'(r[W]));
        check("busy_done", 64'(busy), 64'(1));
        check("ready_done", 64'(start_ready), 64'(0));
        exp_sum   = r[W-1:0];
        exp_carry = r[W];
    endtask

    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc);
        check("ready_idle", 64'(start_ready), 64'(1));
        a           = oa;
        b           = ob;
        cin         = oc;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        finish_op(oa, ob, oc, 1'b0);
        step();
        check("done_low", 64'(done), 64'(0));
        check("busy_idle", 64'(busy), 64'(0));
        check("ready_after", 64'(start_ready), 64'(1));
        check("sum_kept", 64'(sum), 64'(exp_sum));
    endtask

    initial begin
        rst_n       = 1'b0;
        start_valid = 1'b0;
        abort       = 1'b0;
        a           = '0;
        b           = '0;
        cin         = 1'b0;
        exp_sum     = '0;
        exp_carry   = 1'b0;
        step();
        step();
        check("rst_ready", 64'(start_ready), 64'(0));
        rst_n = 1'b1;
        #1;
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_carry", 64'(carry), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready_hi", 64'(start_ready), 64'(1));

        // Full carry ripple and the cin path.
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

        // Back-to-back with start_valid held: second acceptance lands N+2 edges later.
        a = 32'h0000_0001; b = 32'h0000_0002; cin = 1'b0; start_valid = 1'b1;
        step();
        a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b0;
        finish_op(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1);
        step();
        check("b2b_ready", 64'(start_ready), 64'(1));
        check("b2b_busy_gap", 64'(busy), 64'(0));
        step();
        start_valid = 1'b0;
        finish_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        step();
        check("b2b_done_low", 64'(done), 64'(0));

        // Abort on the second RUN edge leaves the previous result untouched.
        run_op(32'h0000_0010, 32'h0000_0020, 1'b0);
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_ready", 64'(start_ready), 64'(1));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        for (int k = 0; k < int'(N); k++) begin
            check("abort_no_done", 64'(done), 64'(0));
            check("abort_sum", 64'(sum), 64'(exp_sum));
            check("abort_carry", 64'(carry), 64'(exp_carry));
            step();
        end
        // Abort outside RUN has no effect on a following operation.
        abort = 1'b1;
        step();
        abort = 1'b0;
        run_op(32'h0000_0003, 32'h0000_0004, 1'b1);

        // Reset mid-run (with abort also high) returns to IDLE and clears the result.
        run_op(32'hF000_0000, 32'h1000_0000, 1'b0);
        a = 32'h0101_0101; b = 32'h0202_0202; cin = 1'b0; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step();
        rst_n = 1'b0;
        abort = 1'b1;
        step();
        rst_n = 1'b1;
        abort = 1'b0;
        #1;
        exp_sum   = '0;
        exp_carry = 1'b0;
        check("mrst_sum", 64'(sum), 64'(0));
        check("mrst_carry", 64'(carry), 64'(0));
        check("mrst_done", 64'(done), 64'(0));
        check("mrst_busy", 64'(busy), 64'(0));
        check("mrst_ready", 64'(start_ready), 64'(1));
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0);

        // Randomized operations, with occasional idle gaps.
        for (int t = 0; t < 40; t++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net against a hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

endmodule
